hex_scroll_ctrl: RTL and testbench

Scroll scheduler for the four-digit HEX display bank. Holds an up-to-8-symbol message buffer, generates the scroll tick from CLOCK_50, and drives four 4-bit symbol codes into the existing per-digit seven-segment decoders. The surrounding design can load the buffer, start, pause, stop and reverse scrolling at run time.

---
 rtl/hex_scroll_pkg.sv | 40 ++++
 rtl/hex_scroll_ctrl_if.sv | 32 +++
 rtl/tick_divider.sv | 34 +++
 rtl/hex_scroll_ctrl.sv | 119 +++++++++++
 tb/tb_hex_scroll_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/hex_scroll_pkg.sv
// Shared definitions for the HEX display scroll scheduler.
// Contents: FSM state type, buffer/field widths, reset buffer pattern,
// message length clamp and the window index wrap helper.
package hex_scroll_pkg;

  localparam int unsigned MSG_DEPTH = 8;
  localparam int unsigned SYM_W     = 4;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned LEN_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  // Buffer contents after reset: entry i holds symbol i.
  function automatic logic [SYM_W-1:0] reset_sym(input logic [ADDR_W-1:0] idx);
    return SYM_W'(idx);
  endfunction

  // Out-of-range lengths (0, 9..15) select the full buffer.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len == '0 || len > LEN_W'(MSG_DEPTH)) return LEN_W'(MSG_DEPTH);
    return len;
  endfunction

  // (ptr + k) mod len for ptr < len and k <= 3; len = 1 needs at most
  // three subtractions, so a fixed three-step loop covers every case.
  function automatic logic [ADDR_W-1:0] wrap_idx(input logic [LEN_W-1:0] sum,
                                                 input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] s;
    s = sum;
    for (int i = 0; i < 3; i++) begin
      if (s >= len) s = s - len;
    end
    return ADDR_W'(s);
  endfunction

endpackage

// File: rtl/hex_scroll_ctrl_if.sv
// Control/display bundle between the surrounding design and hex_scroll_ctrl.
// master: drives write port, start/stop/dir/len; observes display and status.
// slave : the scroll controller.
interface hex_scroll_ctrl_if;
  import hex_scroll_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [SYM_W-1:0]  wr_data;
  logic              wr_ready;
  logic              start;
  logic              stop;
  logic              dir;
  logic [LEN_W-1:0]  len;
  logic [SYM_W-1:0]  digit3;
  logic [SYM_W-1:0]  digit2;
  logic [SYM_W-1:0]  digit1;
  logic [SYM_W-1:0]  digit0;
  logic              busy;
  logic              tick;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, dir, len,
    input  wr_ready, digit3, digit2, digit1, digit0, busy, tick
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, dir, len,
    output wr_ready, digit3, digit2, digit1, digit0, busy, tick
  );

endinterface

// File: rtl/tick_divider.sv
// Scroll step divider: counts CLOCK_50 cycles while enabled and flags the
// last cycle of each TICK_DIV-cycle period.
// Ports: CLOCK_50 clock, resetn async active-low reset, en count enable,
//        clr synchronous clear (wins over en), tick combinational step pulse.
module tick_divider #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned      CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Pulse is a decode of the held count, so it drops as soon as en drops.
  assign tick = en && (cnt_q == CNT_MAX);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      if (cnt_q == CNT_MAX) cnt_q <= '0;
      else                  cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Scroll scheduler for the four-digit HEX display bank.
// Holds an 8-entry symbol buffer, steps a window pointer on each scroll tick
// and presents four registered symbol codes (digit3 leftmost).
// Ports: CLOCK_50 clock, resetn async active-low reset,
//        bus (slave): write port, start/stop/dir/len controls,
//        digit3..0 outputs, busy/wr_ready status, tick step pulse.
module hex_scroll_ctrl
  import hex_scroll_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned MSG_DEPTH = hex_scroll_pkg::MSG_DEPTH
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  hex_scroll_ctrl_if.slave   bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [SYM_W-1:0]  msg_buf [MSG_DEPTH];
  logic [SYM_W-1:0]  dig3_q, dig2_q, dig1_q, dig0_q;
  logic              cnt_en;
  logic              cnt_clr;
  logic              tick_c;

  // Step timer runs only in RUN so a pause freezes it mid-period.
  assign cnt_en = (state_q == RUN);

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .tick     (tick_c)
  );

  // State register.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, pointer/length update and counter clear. stop beats start.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    cnt_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = RUN;
          len_d   = clamp_len(bus.len);
          ptr_d   = '0;
          cnt_clr = 1'b1;
        end
      end
      RUN: begin
        if (tick_c) begin
          if (bus.dir) begin
            ptr_d = (ptr_q == '0) ? ADDR_W'(len_q - LEN_W'(1)) : ptr_q - ADDR_W'(1);
          end else begin
            ptr_d = (LEN_W'(ptr_q) == len_q - LEN_W'(1)) ? '0 : ptr_q + ADDR_W'(1);
          end
        end
        if (bus.stop) state_d = PAUSE;
      end
      PAUSE: begin
        if (bus.stop) begin
          state_d = IDLE;
          ptr_d   = '0;
          cnt_clr = 1'b1;
        end else if (bus.start) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Buffer, pointer, length and display window. The window uses the next
  // pointer so a step shows on the tick edge, while a buffer write shows
  // one edge after it lands.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      ptr_q  <= '0;
      len_q  <= LEN_W'(MSG_DEPTH);
      for (int unsigned i = 0; i < MSG_DEPTH; i++) begin
        msg_buf[ADDR_W'(i)] <= reset_sym(ADDR_W'(i));
      end
      dig3_q <= reset_sym(ADDR_W'(0));
      dig2_q <= reset_sym(ADDR_W'(1));
      dig1_q <= reset_sym(ADDR_W'(2));
      dig0_q <= reset_sym(ADDR_W'(3));
    end else begin
      ptr_q  <= ptr_d;
      len_q  <= len_d;
      if (bus.wr_en && (state_q != RUN)) begin
        msg_buf[bus.wr_addr] <= bus.wr_data;
      end
      dig3_q <= msg_buf[ptr_d];
      dig2_q <= msg_buf[wrap_idx(LEN_W'(ptr_d) + LEN_W'(1), len_d)];
      dig1_q <= msg_buf[wrap_idx(LEN_W'(ptr_d) + LEN_W'(2), len_d)];
      dig0_q <= msg_buf[wrap_idx(LEN_W'(ptr_d) + LEN_W'(3), len_d)];
    end
  end

  assign bus.wr_ready = (state_q != RUN);
  assign bus.busy     = (state_q == RUN);
  assign bus.tick     = tick_c;
  assign bus.digit3   = dig3_q;
  assign bus.digit2   = dig2_q;
  assign bus.digit1   = dig1_q;
  assign bus.digit0   = dig0_q;

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Bench for hex_scroll_ctrl with TICK_DIV = 4. Stimulus pushes the expected
// tick cycle and display word into a queue; a negedge monitor pops an entry
// on every tick and checks the display one edge later.
module tb_hex_scroll_ctrl;

  logic CLOCK_50 = 1'b0;
  logic resetn;

  always #5 CLOCK_50 = ~CLOCK_50;

  hex_scroll_ctrl_if bus();

  hex_scroll_ctrl #(.TICK_DIV(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus)
  );

  typedef struct {
    int          cyc;
    logic [15:0] dig;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge CLOCK_50) cyc++;

  function automatic logic [15:0] digits_now();
    return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_tick(input int c, input logic [15:0] d);
    exp_t e;
    e.cyc = c;
    e.dig = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor.
  logic mon_pend = 1'b0;
  exp_t mon_exp;

  always @(negedge CLOCK_50) begin
    if (mon_pend) begin
      check("digits_after_tick", 32'(digits_now()), 32'(mon_exp.dig));
      mon_pend = 1'b0;
    end
    if (bus.tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tick", 32'(bus.tick), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("tick_cycle", cyc, mon_exp.cyc);
        mon_pend = 1'b1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [3:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    step(1);
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse(input logic do_start, input logic do_stop, output int c0);
    c0        = cyc;
    bus.start = do_start;
    bus.stop  = do_stop;
    step(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: run did not complete, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int d0;
    int f0;
    int g0;

    resetn      = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.dir     = 1'b0;
    bus.len     = 4'd8;

    // 1: reset state and quiet idle
    step(2);
    check("reset_digits", 32'(digits_now()), 32'h0123);
    check("reset_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("reset_busy", 32'(bus.busy), 32'd0);
    resetn = 1'b1;
    step(20);
    check("idle_digits", 32'(digits_now()), 32'h0123);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_tick", 32'(bus.tick), 32'd0);

    // 2: four-symbol message scrolling left
    wr(3'd0, 4'hD); wr(3'd1, 4'hE); wr(3'd2, 4'h0); wr(3'd3, 4'hF);
    wr(3'd4, 4'h0); wr(3'd5, 4'h0); wr(3'd6, 4'h0); wr(3'd7, 4'h0);
    step(1);
    check("loaded_digits", 32'(digits_now()), 32'hDE0F);
    bus.len = 4'd4;
    bus.dir = 1'b0;
    pulse(1'b1, 1'b0, c0);
    expect_tick(c0 + 4,  16'hE0FD);
    expect_tick(c0 + 8,  16'h0FDE);
    expect_tick(c0 + 12, 16'hFDE0);
    expect_tick(c0 + 16, 16'hDE0F);
    check("run_busy", 32'(bus.busy), 32'd1);
    check("run_wr_ready", 32'(bus.wr_ready), 32'd0);
    step(16);
    pulse(1'b0, 1'b1, c0);
    check("pause_busy", 32'(bus.busy), 32'd0);
    check("pause_digits", 32'(digits_now()), 32'hDE0F);
    pulse(1'b0, 1'b1, c0);
    check("idle2_busy", 32'(bus.busy), 32'd0);

    // 3: full-length message, right then left
    for (int i = 0; i < 8; i++) wr(3'(i), 4'(i));
    step(1);
    check("restored_digits", 32'(digits_now()), 32'h0123);
    bus.len = 4'd8;
    bus.dir = 1'b1;
    pulse(1'b1, 1'b0, c0);
    expect_tick(c0 + 4, 16'h7012);
    step(4);
    bus.dir = 1'b0;
    expect_tick(c0 + 8, 16'h0123);
    step(4);

    // 4: write dropped in RUN, accepted in PAUSE
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd0;
    bus.wr_data = 4'h9;
    check("run_write_blocked", 32'(bus.wr_ready), 32'd0);
    step(1);
    bus.wr_en = 1'b0;
    check("run_write_dropped", 32'(digits_now()), 32'h0123);
    pulse(1'b0, 1'b1, c0);
    check("pause4_busy", 32'(bus.busy), 32'd0);
    check("pause4_wr_ready", 32'(bus.wr_ready), 32'd1);
    wr(3'd0, 4'h9);
    check("pause_write_1edge", 32'(digits_now()), 32'h0123);
    step(1);
    check("pause_write_2edge", 32'(digits_now()), 32'h9123);

    // 5: resume, start+stop collision, resume, stop to idle
    pulse(1'b1, 1'b0, d0);
    expect_tick(d0 + 2, 16'h1234);
    step(2);
    pulse(1'b1, 1'b1, c0);
    check("collide_busy", 32'(bus.busy), 32'd0);
    step(8);
    check("collide_frozen", 32'(digits_now()), 32'h1234);
    pulse(1'b1, 1'b0, f0);
    expect_tick(f0 + 3, 16'h2345);
    check("resume_busy", 32'(bus.busy), 32'd1);
    step(3);
    pulse(1'b0, 1'b1, c0);
    check("pause5_digits", 32'(digits_now()), 32'h2345);
    pulse(1'b0, 1'b1, c0);
    check("idle5_digits", 32'(digits_now()), 32'h9123);
    check("idle5_busy", 32'(bus.busy), 32'd0);

    // 6: asynchronous reset mid-run
    pulse(1'b1, 1'b0, g0);
    expect_tick(g0 + 4, 16'h1234);
    step(5);
    resetn = 1'b0;
    #1;
    check("async_rst_digits", 32'(digits_now()), 32'h0123);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("async_rst_tick", 32'(bus.tick), 32'd0);
    step(2);
    resetn = 1'b1;
    step(12);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("post_rst_digits", 32'(digits_now()), 32'h0123);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
